// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, checks it, and performs
// the access on an internal XLEN-wide RAM after WAIT_CYCLES wait states.
module dmem_responder #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic            mem_read_req,
    input  logic            mem_write_req,
    input  logic [2:0]      mem_size,
    input  logic            mem_signed,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_ready,
    output logic            mem_error
);

    localparam int unsigned NBYTES    = XLEN / 8;
    localparam int unsigned LANE_W    = $clog2(NBYTES);
    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [XLEN:0] BASE_E  = {1'b0, BASE_ADDR[XLEN-1:0]};
    localparam logic [XLEN:0] LIMIT_E = BASE_E + (XLEN+1)'(DEPTH_WORDS * NBYTES);
    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [2:0] MAX_SIZE   = 3'(LANE_W);
    localparam bit         DIRECT     = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
    logic [2:0]        size_q;
    logic              signed_q, wr_q, err_q, run_q;
    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    logic              req, accept, fault, commit;
    logic [LANE_W-1:0] amask;
    logic [XLEN:0]     addr_e;

    logic [XLEN-1:0]   cur_addr, cur_wdata, offs, old_word, new_word, wsh, sh, ld_word;
    logic [2:0]        cur_size, cur_sz;
    logic              cur_signed, cur_wr, top;
    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  idx;
    int unsigned       lane_u, nb, nbits;

    assign req    = mem_read_req | mem_write_req;
    assign accept = (state_q == S_IDLE) && req && run_q;
    assign addr_e = {1'b0, mem_addr};

    always_comb begin
        amask = '0;
        for (int unsigned i = 0; i < LANE_W; i++) begin
            if (i < 32'(mem_size)) amask[i] = 1'b1;
        end
    end

    assign fault = (mem_read_req & mem_write_req)
                 | (mem_size > MAX_SIZE)
                 | ((mem_addr[LANE_W-1:0] & amask) != '0)
                 | (addr_e < BASE_E)
                 | (addr_e >= LIMIT_E);

    // With no wait states the access commits on the accept edge, straight from the ports.
    assign cur_addr   = DIRECT ? mem_addr      : addr_q;
    assign cur_wdata  = DIRECT ? mem_wdata     : wdata_q;
    assign cur_size   = DIRECT ? mem_size      : size_q;
    assign cur_signed = DIRECT ? mem_signed    : signed_q;
    assign cur_wr     = DIRECT ? mem_write_req : wr_q;

    assign commit = DIRECT ? (accept && !fault)
                           : ((state_q == S_WAIT) && (cnt_q <= 4'd1) && !err_q);

    assign cur_sz   = (cur_size > MAX_SIZE) ? MAX_SIZE : cur_size;
    assign offs     = cur_addr - BASE_ADDR[XLEN-1:0];
    assign idx      = IDX_W'(offs >> LANE_W);
    assign lane     = cur_addr[LANE_W-1:0];
    assign old_word = mem_q[idx];

    always_comb begin
        lane_u   = 32'(lane);
        nb       = 32'd1 << cur_sz;
        nbits    = 32'd8 << cur_sz;
        wsh      = cur_wdata << {lane, 3'b000};
        sh       = old_word >> {lane, 3'b000};
        new_word = old_word;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (b >= lane_u && b < lane_u + nb) new_word[8*b +: 8] = wsh[8*b +: 8];
        end
        top = 1'b0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i == nbits - 1) top = sh[i];
        end
        ld_word = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            ld_word[i] = (i < nbits) ? sh[i] : (cur_signed & top);
        end
    end

    // Faults still run through the wait states so every response lands WAIT_CYCLES+1 after accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (DIRECT) begin
                        state_d = fault ? S_ERR : S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) state_d = err_q ? S_ERR : S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            run_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            if (accept) begin
                addr_q   <= mem_addr;
                wdata_q  <= mem_wdata;
                size_q   <= mem_size;
                signed_q <= mem_signed;
                wr_q     <= mem_write_req;
                err_q    <= fault;
            end
            if (commit && !cur_wr)       rdata_q <= ld_word;
            else if (state_d == S_ERR)   rdata_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && cur_wr) mem_q[idx] <= new_word;
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = (state_q == S_DONE);
    assign mem_error = (state_q == S_ERR);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked against a
// byte-addressed reference memory and the response-timing rules.
module tb_dmem_responder;

    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam int unsigned RAM_BYTES = 1024 * 8;

    logic        clk = 1'b0;
    logic        rstn [3];
    logic [63:0] addr [3];
    logic [63:0] wdata[3];
    logic [63:0] rdata[3];
    logic        rd   [3];
    logic        wr   [3];
    logic        sgn  [3];
    logic        rdy  [3];
    logic        err  [3];
    logic [2:0]  size [3];

    int          vectors = 0;
    int          miscompares = 0;
    int          wcs [3] = '{1, 0, 3};
    bit   [7:0]  mbytes [3][RAM_BYTES];
    logic [63:0] exp_rd [3];

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(64), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .resetn(rstn[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_read_req(rd[0]), .mem_write_req(wr[0]), .mem_size(size[0]), .mem_signed(sgn[0]),
        .mem_rdata(rdata[0]), .mem_ready(rdy[0]), .mem_error(err[0]));

    dmem_responder #(.XLEN(64), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .resetn(rstn[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_read_req(rd[1]), .mem_write_req(wr[1]), .mem_size(size[1]), .mem_signed(sgn[1]),
        .mem_rdata(rdata[1]), .mem_ready(rdy[1]), .mem_error(err[1]));

    dmem_responder #(.XLEN(64), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .resetn(rstn[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_read_req(rd[2]), .mem_write_req(wr[2]), .mem_size(size[2]), .mem_signed(sgn[2]),
        .mem_rdata(rdata[2]), .mem_ready(rdy[2]), .mem_error(err[2]));

    // Reference model: flat little-endian byte memory.
    function automatic bit mdl_fault(bit r, bit w, logic [63:0] a, logic [2:0] sz);
        if (r && w) return 1'b1;
        if (sz > 3'd3) return 1'b1;
        if ((a % (64'd1 << sz)) != 64'd0) return 1'b1;
        if (a < BASE) return 1'b1;
        if (a >= BASE + RAM_BYTES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] mdl_load(int k, logic [63:0] a, logic [2:0] sz, bit s);
        int unsigned n;
        int unsigned off;
        logic [63:0] v;
        n   = 32'd1 << sz;
        off = 32'(a - BASE);
        v   = 64'd0;
        for (int unsigned i = 0; i < n; i++) v = v | (64'(mbytes[k][off + i]) << (8 * i));
        if (s && n < 8 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic mdl_store(input int k, input logic [63:0] a, input logic [63:0] d, input logic [2:0] sz);
        int unsigned n;
        int unsigned off;
        n   = 32'd1 << sz;
        off = 32'(a - BASE);
        for (int unsigned i = 0; i < n; i++) mbytes[k][off + i] = d[8 * i +: 8];
    endtask

    task automatic access(input int k, input bit r, input bit w, input logic [63:0] a,
                          input logic [63:0] d, input logic [2:0] sz, input bit s,
                          input string nm, output logic [63:0] got);
        bit f;
        logic [63:0] e;
        int lat;
        f = mdl_fault(r, w, a, sz);
        if (f)      e = 64'd0;
        else if (r) e = mdl_load(k, a, sz, s);
        else        e = exp_rd[k];
        @(posedge clk); #1;
        addr[k] = a; wdata[k] = d; size[k] = sz; sgn[k] = s; rd[k] = r; wr[k] = w;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy[k] || err[k]) begin
                lat = n;
                break;
            end
        end
        rd[k] = 1'b0; wr[k] = 1'b0;
        got = rdata[k];
        vectors++;
        if (lat < 0) begin
            miscompares++;
            $display("FAIL %s timeout: no ready/error within 40 cycles", nm);
        end else begin
            vectors++;
            if (err[k] !== f) begin
                miscompares++;
                $display("FAIL %s error: got %b want %b (addr %h size %0d)", nm, err[k], f, a, sz);
            end
            vectors++;
            if (rdy[k] !== !f) begin
                miscompares++;
                $display("FAIL %s ready: got %b want %b (addr %h size %0d)", nm, rdy[k], !f, a, sz);
            end
            if (lat != wcs[k] + 1) begin
                miscompares++;
                $display("FAIL %s latency: got %0d want %0d", nm, lat, wcs[k] + 1);
            end
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s rdata: got %h want %h (addr %h size %0d)", nm, got, e, a, sz);
            end
        end
        if (!f && w) mdl_store(k, a, d, sz);
        exp_rd[k] = e;
        @(negedge clk);
        vectors++;
        if (rdy[k] !== 1'b0 || err[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse width: ready %b error %b want 0 0", nm, rdy[k], err[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (rdy[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d]: got %b %b %h want 0 0 0", k, rdy[k], err[k], rdata[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (rdy[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 64'd0) begin
                miscompares++;
                $display("FAIL idle_outputs[%0d]: got %b %b %h want 0 0 0", k, rdy[k], err[k], rdata[k]);
            end
        end
    endtask

    task automatic test_sd_ld();
        logic [63:0] got;
        access(0, 1'b0, 1'b1, BASE + 64'h8, 64'h1122334455667788, 3'd3, 1'b0, "sd", got);
        access(0, 1'b1, 1'b0, BASE + 64'h8, 64'd0, 3'd3, 1'b0, "ld", got);
        vectors++;
        if (got !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL sd_ld value: got %h want %h", got, 64'h1122334455667788);
        end
    endtask

    task automatic test_byte_lanes();
        logic [63:0] got;
        logic [63:0] want [5] = '{64'h0000_0000_0000_00AB, 64'hFFFF_FFFF_FFFF_FFAB,
                                   64'hFFFF_FFFF_AB00_0000, 64'h0000_0000_AB00_0000,
                                   64'h1234_0000_AB00_0000};
        logic [63:0] seen [5];
        access(0, 1'b0, 1'b1, BASE, 64'd0, 3'd3, 1'b0, "clr", got);
        access(0, 1'b0, 1'b1, BASE + 64'h3, 64'hFFFF_FFFF_FFFF_FFAB, 3'd0, 1'b0, "sb", got);
        access(0, 1'b1, 1'b0, BASE + 64'h3, 64'd0, 3'd0, 1'b0, "lbu", seen[0]);
        access(0, 1'b1, 1'b0, BASE + 64'h3, 64'd0, 3'd0, 1'b1, "lb", seen[1]);
        access(0, 1'b1, 1'b0, BASE, 64'd0, 3'd2, 1'b1, "lw", seen[2]);
        access(0, 1'b1, 1'b0, BASE, 64'd0, 3'd2, 1'b0, "lwu", seen[3]);
        access(0, 1'b0, 1'b1, BASE + 64'h6, 64'h5555_5555_5555_1234, 3'd1, 1'b0, "sh", got);
        access(0, 1'b1, 1'b0, BASE, 64'd0, 3'd3, 1'b1, "ld0", seen[4]);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (seen[i] !== want[i]) begin
                miscompares++;
                $display("FAIL byte_lane[%0d]: got %h want %h", i, seen[i], want[i]);
            end
        end
    endtask

    task automatic test_faults();
        logic [63:0] got;
        access(0, 1'b1, 1'b0, BASE + 64'h8, 64'd0, 3'd3, 1'b0, "ld_pre", got);
        access(0, 1'b1, 1'b0, BASE + 64'h2, 64'd0, 3'd2, 1'b0, "lw_misalign", got);
        access(0, 1'b1, 1'b0, 64'h7FFF_FFF8, 64'd0, 3'd3, 1'b0, "ld_below", got);
        access(0, 1'b1, 1'b0, 64'h8000_2000, 64'd0, 3'd3, 1'b0, "ld_above", got);
        access(0, 1'b1, 1'b0, BASE + 64'h8, 64'd0, 3'd3, 1'b0, "ld_pre2", got);
        access(0, 1'b1, 1'b1, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 1'b0, "rd_wr_both", got);
        access(0, 1'b1, 1'b0, BASE, 64'd0, 3'd3, 1'b0, "ld_after_err", got);
        vectors++;
        if (got !== 64'h1234_0000_AB00_0000) begin
            miscompares++;
            $display("FAIL ram_after_err: got %h want %h", got, 64'h1234_0000_AB00_0000);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got;
        logic [63:0] v;
        logic exp;
        int pulses;
        v = 64'h0F0E_0D0C_0B0A_0908;
        access(1, 1'b0, 1'b1, BASE + 64'h20, v, 3'd3, 1'b0, "b2b_sd", got);
        pulses = 0;
        @(posedge clk); #1;
        addr[1] = BASE + 64'h20; size[1] = 3'd3; sgn[1] = 1'b0; rd[1] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            exp = (n < 6) && (n % 2 == 1);
            if (rdy[1]) pulses++;
            vectors++;
            if (rdy[1] !== exp) begin
                miscompares++;
                $display("FAIL b2b_ready cycle %0d: got %b want %b", n, rdy[1], exp);
            end
            if (exp) begin
                vectors++;
                if (rdata[1] !== v) begin
                    miscompares++;
                    $display("FAIL b2b_rdata cycle %0d: got %h want %h", n, rdata[1], v);
                end
            end
            if (n == 5) rd[1] = 1'b0;
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d want 3", pulses);
        end
        exp_rd[1] = v;
    endtask

    task automatic test_reset_wait();
        logic [63:0] got;
        logic [63:0] old;
        old = 64'h0123_4567_89AB_CDEF;
        access(2, 1'b0, 1'b1, BASE + 64'h10, old, 3'd3, 1'b0, "rw_sd_old", got);
        access(2, 1'b1, 1'b0, BASE + 64'h10, 64'd0, 3'd3, 1'b0, "rw_ld_old", got);
        @(posedge clk); #1;
        addr[2] = BASE + 64'h10; wdata[2] = 64'hDEAD; size[2] = 3'd3; sgn[2] = 1'b0; wr[2] = 1'b1;
        repeat (2) @(negedge clk);
        rstn[2] = 1'b0;
        #1;
        vectors++;
        if (rdy[2] !== 1'b0 || err[2] !== 1'b0 || rdata[2] !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_in_wait outputs: got %b %b %h want 0 0 0", rdy[2], err[2], rdata[2]);
        end
        wr[2] = 1'b0;
        @(negedge clk);
        rstn[2] = 1'b1;
        exp_rd[2] = 64'd0;
        access(2, 1'b1, 1'b0, BASE + 64'h10, 64'd0, 3'd3, 1'b0, "rw_ld_after", got);
        vectors++;
        if (got !== old) begin
            miscompares++;
            $display("FAIL reset_in_wait ram: got %h want %h", got, old);
        end
    endtask

    task automatic test_flush();
        logic [63:0] got;
        logic [63:0] v;
        logic exp;
        v = {$urandom, $urandom};
        access(0, 1'b0, 1'b1, BASE + 64'h18, v, 3'd3, 1'b0, "flush_sd", got);
        @(posedge clk); #1;
        addr[0] = BASE + 64'h18; size[0] = 3'd3; sgn[0] = 1'b0; rd[0] = 1'b1;
        @(posedge clk); #1;
        rd[0] = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            exp = (n == 2);
            vectors++;
            if (rdy[0] !== exp || err[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_ready cycle %0d: got %b/%b want %b/0", n, rdy[0], err[0], exp);
            end
            if (exp) begin
                vectors++;
                if (rdata[0] !== v) begin
                    miscompares++;
                    $display("FAIL flush_rdata: got %h want %h", rdata[0], v);
                end
            end
        end
        exp_rd[0] = v;
    endtask

    task automatic test_random();
        logic [63:0] got;
        logic [63:0] a;
        logic [2:0]  sz;
        int kind;
        int region;
        bit r;
        bit w;
        for (int i = 0; i < 8; i++)
            access(0, 1'b0, 1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 3'd3, 1'b0, "rand_init", got);
        access(0, 1'b0, 1'b1, BASE + RAM_BYTES - 8, {$urandom, $urandom}, 3'd3, 1'b0, "rand_init_top", got);
        for (int i = 0; i < 80; i++) begin
            kind   = int'($urandom_range(0, 9));
            region = int'($urandom_range(0, 9));
            r = (kind < 5) || (kind == 9);
            w = (kind >= 5);
            if (region < 8)       a = BASE + 64'($urandom_range(0, 63));
            else if (region == 8) a = BASE - 64'($urandom_range(1, 16));
            else                  a = BASE + RAM_BYTES - 8 + 64'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 9) sz = 3'($urandom_range(0, 3));
            else                          sz = 3'($urandom_range(4, 7));
            access(0, r, w, a, {$urandom, $urandom}, sz, 1'($urandom_range(0, 1)), "rand", got);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rstn[k] = 1'b0; addr[k] = '0; wdata[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0;
            sgn[k] = 1'b0; size[k] = '0; exp_rd[k] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_sd_ld();
        test_byte_lanes();
        test_faults();
        test_back_to_back();
        test_reset_wait();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
